// File: rtl/trackball_pkg.sv
// Shared definitions for the trackball quadrature counter: default counter width,
// axis channel numbering and the count type used on the CPU-facing side.
package trackball_pkg;

    localparam int DEF_CNT_W = 4;

    // Channel index of each axis; also the index into the per-axis state arrays.
    typedef enum logic [1:0] {
        P1H = 2'd0,
        P1V = 2'd1,
        P2H = 2'd2,
        P2V = 2'd3
    } axis_e;

    typedef logic [DEF_CNT_W-1:0] tb_cnt_t;

endpackage

// File: rtl/quad_axis_counter.sv
// One trackball axis: synchronises the asynchronous direction/pulse pair,
// detects rising edges of the pulse and keeps a wrapping up/down position
// count plus the direction of the most recent step.
module quad_axis_counter #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_async,
    input  logic             clk_async,
    input  logic             clr_cnt,
    input  logic             clr_dir,
    output logic [CNT_W-1:0] cnt,
    output logic             dir_flag
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // dir and clk share identically shaped chains so they stay cycle-aligned.
    logic [SYNC_STAGES-1:0] dir_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic                   clk_prev;
    // vld_p[k] marks that stage k holds a sample taken after reset; the last bit
    // covers clk_prev. A pulse held high through reset therefore never looks like
    // a fresh 0->1 transition, and anything pending in the chain is dropped.
    logic [SYNC_STAGES:0]   vld_p;

    logic dir_s;
    logic clk_s;
    logic step;

    // Modulo-2^CNT_W up/down step; wrap-around is silent by design.
    function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] c,
                                                    input logic             up);
        return up ? (c + CNT_ONE) : (c - CNT_ONE);
    endfunction

    assign dir_s = dir_sync[SYNC_STAGES-1];
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign step  = vld_p[SYNC_STAGES] & clk_s & ~clk_prev;

    // Synchroniser chains, previous-sample register and post-reset sample tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_sync <= '0;
            clk_sync <= '0;
            clk_prev <= 1'b0;
            vld_p    <= '0;
        end else begin
            dir_sync <= {dir_sync[SYNC_STAGES-2:0], dir_async};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], clk_async};
            clk_prev <= clk_s;
            vld_p    <= {vld_p[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Position counter: the clear wins over a coincident step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= step_count(cnt, dir_s);
        end
    end

    // Direction flag follows the direction of each step unless cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_flag <= 1'b0;
        end else if (clr_dir) begin
            dir_flag <= 1'b0;
        end else if (step) begin
            dir_flag <= dir_s;
        end
    end

endmodule

// File: rtl/trackball_quad_counter.sv
// Both players' trackballs: four axis counters, clear fan-out and the
// cocktail-cabinet flip mux that selects which player the CPU reads.
module trackball_quad_counter
    import trackball_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       hordir,
    input  logic [1:0]       horclk,
    input  logic [1:0]       verdir,
    input  logic [1:0]       verclk,
    input  logic             rstclr_l,
    input  logic             steerclr,
    input  logic             flip,
    output logic [CNT_W-1:0] tra,
    output logic [CNT_W-1:0] trb,
    output logic             dir1,
    output logic             dir2
);

    localparam int N_AXES = 4;

    logic [N_AXES-1:0] dir_async;
    logic [N_AXES-1:0] clk_async;
    logic [N_AXES-1:0] flag_v;
    logic [CNT_W-1:0]  cnt_a [N_AXES];
    logic              clr_cnt;
    logic              clr_dir;

    // Input bit [1] belongs to player 1, bit [0] to player 2.
    assign dir_async[P1H] = hordir[1];
    assign clk_async[P1H] = horclk[1];
    assign dir_async[P1V] = verdir[1];
    assign clk_async[P1V] = verclk[1];
    assign dir_async[P2H] = hordir[0];
    assign clk_async[P2H] = horclk[0];
    assign dir_async[P2V] = verdir[0];
    assign clk_async[P2V] = verclk[0];

    assign clr_cnt = ~rstclr_l;
    assign clr_dir = steerclr;

    for (genvar a = 0; a < N_AXES; a++) begin : g_axis
        quad_axis_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_axis (
            .clk       (clk),
            .rst       (rst),
            .dir_async (dir_async[a]),
            .clk_async (clk_async[a]),
            .clr_cnt   (clr_cnt),
            .clr_dir   (clr_dir),
            .cnt       (cnt_a[a]),
            .dir_flag  (flag_v[a])
        );
    end

    // Present the selected player's registered state; flip acts without delay.
    always_comb begin
        tra  = cnt_a[P1H];
        trb  = cnt_a[P1V];
        dir1 = flag_v[P1H];
        dir2 = flag_v[P1V];
        if (flip) begin
            tra  = cnt_a[P2H];
            trb  = cnt_a[P2V];
            dir1 = flag_v[P2H];
            dir2 = flag_v[P2V];
        end
    end

endmodule
